// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   state_e      - responder FSM state encoding
//   WORD_BYTES   - bytes per array word
//   WORD_LSB     - byte-address bit where the word index starts
//   addr_fault() - alignment and range check of a byte address against a word depth
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_LSB   = $clog2(WORD_BYTES);

    // A word access faults when it is not word aligned or its word index lies
    // outside an array of 'depth' words. Also used by the instruction-side loader.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit data storage: synchronous write, asynchronous read.
// Contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - word index written on the rising edge when we is high
//   wdata - write data
//   raddr - word index read combinationally
//   rdata - read data
module dmem_array #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface. Services one load or
// store at a time with LATENCY cycles from acceptance to the response strobe,
// holding the pipeline via stall until the response cycle. Misaligned and
// out-of-range accesses return resp_err and never touch the array.
// Ports:
//   clk, reset (async, active low)      - clock and reset
//   enable                              - global advance; low freezes all state
//   req_valid/req_write/req_addr/req_wdata - request from the MEM stage
//   req_ready                           - request accepted when high with req_valid
//   stall                               - freeze IF/ID/EX/MEM pipeline registers
//   resp_valid/resp_rdata/resp_err      - response, valid during the RESP cycle
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        enter_resp;
    logic [31:0] addr_in;
    logic        wr_in;
    logic        fault_in;
    logic        mem_we;
    logic [31:0] mem_rdata;

    assign req_ready  = enable & (state_q == StIdle);
    assign accept     = req_valid & req_ready;
    assign stall      = ((state_q == StIdle) & req_valid) | (state_q == StWait);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Access about to enter RESP: with LATENCY=1 it comes straight from the ports.
    assign addr_in  = (state_q == StIdle) ? req_addr : addr_q;
    assign wr_in    = (state_q == StIdle) ? req_write : wr_q;
    assign fault_in = addr_fault(addr_in, DEPTH);

    // Stores commit on the edge leaving RESP, before any later access is accepted.
    assign mem_we = enable & (state_q == StResp) & wr_q & ~addr_fault(addr_q, DEPTH);

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(addr_q[WORD_LSB +: AW]),
        .wdata(wdata_q),
        .raddr(addr_in[WORD_LSB +: AW]),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        wr_d    = req_write;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        if (LATENCY == 1) begin
                            state_d    = StResp;
                            enter_resp = 1'b1;
                        end else begin
                            cnt_d   = 4'(LATENCY - 1);
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
                StResp: begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end

        if (enter_resp) begin
            err_d   = fault_in;
            rdata_d = (fault_in || wr_in) ? 32'h0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Three instances (LATENCY 1, 2, 4)
// share the request bus and reset; each has its own req_valid. Expected
// responses come from a per-instance memory model and are queued at issue time.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  vld;
    wire  [2:0]  rdy;
    wire  [2:0]  stl;
    wire  [2:0]  rv;
    wire  [2:0]  re;
    wire  [31:0] rd [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mem_m [3][DEPTH];
    logic        known [3][DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .enable(enable), .req_valid(vld[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]), .stall(stl[0]),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(re[0])
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .enable(enable), .req_valid(vld[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]), .stall(stl[1]),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(re[1])
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .enable(enable), .req_valid(vld[2]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[2]), .stall(stl[2]),
        .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(re[2])
    );

    function automatic logic bench_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    // Drive a request on instance s, queue its expected response, wait for acceptance.
    // k0 = cycle in which it was accepted; st = stall seen in that cycle.
    task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic hold, input logic commit, output int k0, output logic st);
        exp_t e;
        int   n;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        vld[s]    = 1'b1;
        if (bench_fault(a)) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
        end else if (w) begin
            e.rdata = 32'h0;
            e.err   = 1'b0;
            if (commit) begin
                mem_m[s][a[9:2]] = d;
                known[s][a[9:2]] = 1'b1;
            end
        end else begin
            e.rdata = mem_m[s][a[9:2]];
            e.err   = 1'b0;
        end
        case (s)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        k0 = -1;
        st = 1'b0;
        n  = 0;
        while (k0 < 0 && n < 40) begin
            @(negedge clk);
            if (rdy[s]) begin
                k0 = cyc;
                st = stl[s];
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (k0 < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d addr=%h: req_ready never high", s, a);
        end
        if (!hold) vld[s] = 1'b0;
    endtask

    // Wait for the response strobe of instance s and compare against the scoreboard.
    task automatic wait_resp(input int s, output int kr);
        exp_t e;
        int   n;
        int   sz;
        kr = -1;
        n  = 0;
        while (kr < 0 && n < 60) begin
            @(negedge clk);
            if (rv[s] && enable) kr = cyc;
            n++;
        end
        checks++;
        sz = (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
        if (kr < 0) begin
            errors++;
            $display("FAIL resp_timeout dut%0d: got no resp_valid, required one", s);
        end else if (sz == 0) begin
            errors++;
            $display("FAIL resp_unexpected dut%0d: got resp_valid, required none", s);
        end else begin
            case (s)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            if (rd[s] !== e.rdata || re[s] !== e.err) begin
                errors++;
                $display("FAIL resp_data dut%0d: got rdata=%h err=%b, required rdata=%h err=%b",
                         s, rd[s], re[s], e.rdata, e.err);
            end
            checks++;
            if (rdy[s] !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_resp dut%0d: got %b, required 0", s, rdy[s]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (rv[s] !== 1'b0 || rd[s] !== 32'h0 || re[s] !== 1'b0 || stl[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got rv=%b rdata=%h err=%b stall=%b, required 0",
                         s, rv[s], rd[s], re[s], stl[s]);
            end
            checks++;
            if (rdy[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready dut%0d: got %b, required 1", s, rdy[s]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int   k;
        int   kr;
        logic st;
        issue(1, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 1'b1, k, st);
        wait_resp(1, kr);
        issue(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, k, st);
        @(negedge clk);
        checks++;
        if (stl[1] !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall: got %b, required 1", stl[1]);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (rv[1] !== 1'b0 || rd[1] !== 32'h0 || re[1] !== 1'b0 || stl[1] !== 1'b0 ||
            rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait: got rv=%b rdata=%h err=%b stall=%b ready=%b, required 0 0 0 0 1",
                     rv[1], rd[1], re[1], stl[1], rdy[1]);
        end
        q1.delete();
        @(negedge clk);
        reset = 1'b1;
        issue(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, k, st);
        wait_resp(1, kr);
    endtask

    task automatic test_latency2();
        int   k0;
        int   k1;
        int   kr;
        int   kr2;
        logic st;
        issue(1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b1, k0, st);
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept_cycle: got %b, required 1", st);
        end
        @(negedge clk);
        checks++;
        if (stl[1] !== 1'b1 || rv[1] !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait_cycle: got stall=%b rv=%b, required 1 0", stl[1], rv[1]);
        end
        wait_resp(1, kr);
        checks++;
        if (kr - k0 != 2) begin
            errors++;
            $display("FAIL store_latency: got %0d, required 2", kr - k0);
        end
        issue(1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, k1, st);
        checks++;
        if (k1 != kr + 1) begin
            errors++;
            $display("FAIL next_accept: got cycle %0d, required %0d", k1, kr + 1);
        end
        wait_resp(1, kr2);
        checks++;
        if (kr2 - k0 != 5) begin
            errors++;
            $display("FAIL load_latency: got T+%0d, required T+5", kr2 - k0);
        end
    endtask

    task automatic test_back_to_back();
        int   k0;
        int   k1;
        int   r0;
        int   r1;
        logic st;
        issue(0, 1'b1, 32'h0, 32'hA5A5_0000, 1'b0, 1'b1, k0, st);
        wait_resp(0, r0);
        issue(0, 1'b1, 32'h4, 32'h5A5A_0004, 1'b0, 1'b1, k0, st);
        wait_resp(0, r0);
        issue(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, k0, st);
        wait_resp(0, r0);
        issue(0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, k1, st);
        wait_resp(0, r1);
        checks++;
        if (k1 - k0 != 2 || r0 != k0 + 1 || r1 != k1 + 1) begin
            errors++;
            $display("FAIL back_to_back: got accept gap %0d resp offsets %0d %0d, required 2 1 1",
                     k1 - k0, r0 - k0, r1 - k1);
        end
        @(negedge clk);
        checks++;
        if (rv[0] !== 1'b0) begin
            errors++;
            $display("FAIL extra_resp: got rv=%b, required 0", rv[0]);
        end
    endtask

    task automatic test_faults();
        int   k;
        int   kr;
        logic st;
        issue(1, 1'b1, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1, k, st);
        wait_resp(1, kr);
        issue(1, 1'b0, 32'h22, 32'h0, 1'b0, 1'b1, k, st);
        wait_resp(1, kr);
        issue(1, 1'b1, 32'h400, 32'hFFFF_FFFF, 1'b0, 1'b1, k, st);
        wait_resp(1, kr);
        issue(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, k, st);
        wait_resp(1, kr);
    endtask

    task automatic test_enable_freeze();
        int   k0;
        int   kr;
        logic st;
        issue(2, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b0, 1'b1, k0, st);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (stl[2] !== 1'b1 || rv[2] !== 1'b0) begin
                errors++;
                $display("FAIL freeze_stall cycle%0d: got stall=%b rv=%b, required 1 0",
                         i, stl[2], rv[2]);
            end
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        wait_resp(2, kr);
        checks++;
        if (kr - k0 != 7) begin
            errors++;
            $display("FAIL freeze_latency: got %0d, required 7", kr - k0);
        end
        issue(2, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, k0, st);
        wait_resp(2, kr);
    endtask

    task automatic test_random();
        localparam int N = 40;
        int          first;
        int          k;
        int          kr;
        int          r;
        int          word;
        logic        w;
        logic [31:0] a;
        logic        st;
        first = 0;
        kr    = 0;
        for (int i = 0; i < N; i++) begin
            r    = int'($urandom_range(0, 9));
            word = int'($urandom_range(0, 15));
            if (r == 0) a = 32'(word * 4) + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h400 + 32'(word * 4);
            else a = 32'(word * 4);
            if (r >= 2 && !known[1][word]) w = 1'b1;
            else w = 1'($urandom_range(0, 1));
            issue(1, w, a, $urandom, 1'b0, 1'b1, k, st);
            if (i == 0) first = k;
            wait_resp(1, kr);
        end
        checks++;
        if (kr - first + 1 != N * 3) begin
            errors++;
            $display("FAIL stream_cycles: got %0d, required %0d", kr - first + 1, N * 3);
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        vld       = 3'b000;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                known[s][j] = 1'b0;
                mem_m[s][j] = 32'h0;
            end
        end
        test_reset();
        test_reset_mid_wait();
        test_latency2();
        test_back_to_back();
        test_faults();
        test_enable_freeze();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
